// File: rtl/my_bus_responder.sv
// Register-bus responder: CTRL, STATUS, DATA FIFO port and SCRATCH.
// Reads return registered data with a one-cycle rdata_valid pulse.
module my_bus_responder #(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] SCRATCH_RST = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] addr,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [7:0] wdata,
    input  logic       valid,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       irq
);

    localparam int         AW       = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam logic [2:0] FULL_CNT = 3'(FIFO_DEPTH);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [2:0]    r_count;
    logic [1:0]    r_ctrl;
    logic          r_ovf;
    logic          r_unf;
    logic          r_perr;
    logic [7:0]    r_scratch;
    logic [7:0]    r_rdata;
    logic          r_rvalid;

    logic       w_wr;
    logic       w_rd;
    logic       w_perr;
    logic       w_empty;
    logic       w_full;
    logic [7:0] w_status;
    logic [7:0] w_rmux;

    assign w_wr    = valid & wr_en & ~rd_en;
    assign w_rd    = valid & rd_en & ~wr_en;
    assign w_perr  = valid & wr_en & rd_en;
    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count == FULL_CNT);

    assign w_status = {r_count, r_perr, r_unf, r_ovf, w_full, w_empty};

    // Read data is taken from pre-access state.
    always_comb begin
        w_rmux = 8'h00;
        case (addr)
            2'd0: w_rmux = {6'b0, r_ctrl};
            2'd1: w_rmux = w_status;
            2'd2: w_rmux = w_empty ? 8'h00 : r_mem[r_rptr];
            2'd3: w_rmux = r_scratch;
            default: w_rmux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= 3'd0;
            r_ctrl    <= 2'b00;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_perr    <= 1'b0;
            r_scratch <= SCRATCH_RST;
            r_rdata   <= 8'h00;
            r_rvalid  <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rmux;
            end
            if (w_perr) begin
                r_perr <= 1'b1;
            end
            if (w_wr) begin
                case (addr)
                    2'd0: begin
                        r_ctrl <= wdata[1:0];
                        if (wdata[2]) begin
                            r_wptr  <= '0;
                            r_rptr  <= '0;
                            r_count <= 3'd0;
                            r_ovf   <= 1'b0;
                            r_unf   <= 1'b0;
                            r_perr  <= 1'b0;
                        end
                    end
                    2'd1: begin
                        if (wdata[2]) r_ovf  <= 1'b0;
                        if (wdata[3]) r_unf  <= 1'b0;
                        if (wdata[4]) r_perr <= 1'b0;
                    end
                    2'd2: begin
                        if (r_ctrl[0]) begin
                            if (w_full) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_mem[r_wptr] <= wdata;
                                r_wptr        <= r_wptr + AW'(1);
                                r_count       <= r_count + 3'd1;
                            end
                        end
                    end
                    2'd3: r_scratch <= wdata;
                    default: ;
                endcase
            end
            // Pops ignore fifo_en.
            if (w_rd && addr == 2'd2) begin
                if (w_empty) begin
                    r_unf <= 1'b1;
                end else begin
                    r_rptr  <= r_rptr + AW'(1);
                    r_count <= r_count - 3'd1;
                end
            end
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_rvalid;
    assign irq         = r_ctrl[1] & (r_ovf | r_unf | r_perr);

endmodule

// File: tb/tb_my_bus_responder.sv
// Scoreboard bench for my_bus_responder: directed plan then random traffic
// against a queue-based register model.
module tb_my_bus_responder;

    localparam int         DEPTH = 4;
    localparam logic [7:0] SRST  = 8'h5A;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] addr = 2'd0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       valid = 1'b0;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];

    bit         m_fen, m_ien, m_ovf, m_unf, m_perr;
    logic [7:0] m_fifo[$];
    logic [7:0] m_scr;

    my_bus_responder #(
        .FIFO_DEPTH (DEPTH),
        .SCRATCH_RST(SRST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wdata      (wdata),
        .valid      (valid),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_irq();
        return m_ien & (m_ovf | m_unf | m_perr);
    endfunction

    task automatic model_reset();
        m_fen  = 0;
        m_ien  = 0;
        m_ovf  = 0;
        m_unf  = 0;
        m_perr = 0;
        m_fifo.delete();
        m_scr  = SRST;
        sb.delete();
    endtask

    task automatic model_step(input bit v, input bit we, input bit re,
                              input logic [1:0] a, input logic [7:0] d);
        int         n;
        logic [7:0] e;
        if (!v) return;
        if (we && re) begin
            m_perr = 1;
        end else if (we) begin
            case (a)
                2'd0: begin
                    m_fen = d[0];
                    m_ien = d[1];
                    if (d[2]) begin
                        m_fifo.delete();
                        m_ovf  = 0;
                        m_unf  = 0;
                        m_perr = 0;
                    end
                end
                2'd1: begin
                    if (d[2]) m_ovf  = 0;
                    if (d[3]) m_unf  = 0;
                    if (d[4]) m_perr = 0;
                end
                2'd2: begin
                    if (m_fen) begin
                        if (m_fifo.size() == DEPTH) m_ovf = 1;
                        else m_fifo.push_back(d);
                    end
                end
                default: m_scr = d;
            endcase
        end else if (re) begin
            n = m_fifo.size();
            case (a)
                2'd0: e = 8'(2 * m_ien + m_fen);
                2'd1: e = 8'(n * 32 + m_perr * 16 + m_unf * 8 + m_ovf * 4
                            + (n == DEPTH ? 2 : 0) + (n == 0 ? 1 : 0));
                2'd2: begin
                    if (n == 0) begin
                        e = 8'h00;
                        m_unf = 1;
                    end else begin
                        e = m_fifo.pop_front();
                    end
                end
                default: e = m_scr;
            endcase
            sb.push_back(e);
        end
    endtask

    // Called between edges; returns 1 time unit after the accepting edge.
    task automatic txn(input bit v, input bit we, input bit re,
                       input logic [1:0] a, input logic [7:0] d);
        valid = v;
        wr_en = we;
        rd_en = re;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_step(v, we, re, a, d);
        #1;
        chk("irq", {7'b0, irq}, {7'b0, m_irq()});
        valid = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a,
                          input logic [7:0] exp);
        txn(1, 0, 1, a, 8'h00);
        chk(name, rdata, exp);
        chk({name, "_vld"}, {7'b0, rdata_valid}, 8'h01);
    endtask

    logic [7:0] last;
    logic [7:0] mexp;

    always @(negedge clk) begin
        if (!reset) begin
            last = 8'h00;
            chk("rdata_in_reset", rdata, 8'h00);
            chk("vld_in_reset", {7'b0, rdata_valid}, 8'h00);
        end else if (rdata_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdata_valid: got 1 expected 0");
            end else begin
                mexp = sb.pop_front();
                chk("sb_rdata", rdata, mexp);
                last = mexp;
            end
        end else begin
            chk("rdata_hold", rdata, last);
        end
    end

    int kind;

    initial begin
        model_reset();
        #1;
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        rd_chk("stat_rst", 2'd1, 8'h01);
        rd_chk("scr_rst", 2'd3, SRST);
        txn(1, 1, 0, 2'd3, 8'hA5);
        rd_chk("scr_wr", 2'd3, 8'hA5);
        txn(0, 1, 0, 2'd3, 8'h3C);
        rd_chk("scr_novalid", 2'd3, 8'hA5);

        txn(1, 1, 0, 2'd0, 8'h01);
        txn(1, 1, 0, 2'd2, 8'h11);
        txn(1, 1, 0, 2'd2, 8'h22);
        txn(1, 1, 0, 2'd2, 8'h33);
        txn(1, 1, 0, 2'd2, 8'h44);
        rd_chk("stat_full", 2'd1, 8'h82);
        txn(1, 1, 0, 2'd2, 8'h55);
        rd_chk("stat_ovf", 2'd1, 8'h86);
        txn(1, 1, 0, 2'd1, 8'h04);
        rd_chk("pop0", 2'd2, 8'h11);
        rd_chk("pop1", 2'd2, 8'h22);
        rd_chk("pop2", 2'd2, 8'h33);
        rd_chk("pop3", 2'd2, 8'h44);
        rd_chk("pop_empty", 2'd2, 8'h00);
        rd_chk("stat_unf", 2'd1, 8'h09);
        txn(1, 1, 0, 2'd0, 8'h03);
        chk("irq_on", {7'b0, irq}, 8'h01);
        txn(1, 1, 0, 2'd1, 8'h08);
        chk("irq_off", {7'b0, irq}, 8'h00);

        txn(1, 1, 1, 2'd3, 8'h77);
        chk("perr_irq", {7'b0, irq}, 8'h01);
        rd_chk("scr_perr", 2'd3, 8'hA5);
        txn(1, 1, 0, 2'd2, 8'h99);
        rd_chk("stat_perr", 2'd1, 8'h30);
        txn(1, 1, 0, 2'd0, 8'h05);
        rd_chk("stat_clr", 2'd1, 8'h01);
        rd_chk("ctrl_clr", 2'd0, 8'h01);

        txn(1, 1, 0, 2'd2, 8'hAB);
        valid = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b1;
        addr  = 2'd2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        valid = 1'b0;
        model_reset();
        #1;
        chk("midrd_rdata", rdata, 8'h00);
        chk("midrd_vld", {7'b0, rdata_valid}, 8'h00);
        chk("midrd_irq", {7'b0, irq}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        rd_chk("stat_after_rst", 2'd1, 8'h01);
        rd_chk("scr_after_rst", 2'd3, SRST);

        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0)
                txn(0, 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
            else if (kind == 1)
                txn(1, 1, 1, 2'($urandom), 8'($urandom));
            else if (kind < 6)
                txn(1, 1, 0, 2'($urandom), 8'($urandom));
            else
                txn(1, 0, 1, 2'($urandom), 8'h00);
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
